main_memory_responder: RTL

- Responder side of the cache-fill memory interface.
- Word-organised main-memory model that accepts one read or write request per cycle and returns read data a fixed LATENCY cycles later, qualified by a one-cycle data_valid pulse.
- Sits below the I- and D-cache fill FSMs, which issue eight back-to-back word reads per block and count data_valid pulses.

---
 rtl/main_memory_responder_pkg.sv | 7 +
 rtl/mem_pipe_stage.sv | 29 ++
 rtl/main_memory_responder.sv | 59 +++++
 3 files changed

// File: rtl/main_memory_responder_pkg.sv
// Shared constants for the cache-fill memory interface.
// The word-index LSB is shared with the fill FSMs so both sides form addresses the same way.
package main_memory_responder_pkg;
  localparam int WORD_WIDTH     = 16;
  localparam int MEM_LATENCY    = 4;
  localparam int WORD_INDEX_LSB = 1;
endpackage

// File: rtl/mem_pipe_stage.sv
// One {valid, data} stage of the read-return pipeline.
// Data is captured only with a valid beat, so the final stage holds the last returned word.
module mem_pipe_stage
  import main_memory_responder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [WORD_WIDTH-1:0] out_data
);

  // Advance the valid bit every cycle; hold data across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {WORD_WIDTH{1'b0}};
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end else begin
        out_data <= out_data;
      end
    end
  end

endmodule

// File: rtl/main_memory_responder.sv
// Word-organised main-memory responder: single-cycle writes, reads returned LATENCY cycles
// later with a one-cycle data_valid pulse. Storage is not reset; the return pipeline is.
module main_memory_responder
  import main_memory_responder_pkg::*;
#(
  parameter int ADDR_BITS  = 16,
  parameter int DEPTH_LOG2 = 15,
  parameter int LATENCY    = MEM_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WORD_WIDTH-1:0]              mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0]              index_s;
  logic [LATENCY:0]                   valid_s;
  logic [LATENCY:0][WORD_WIDTH-1:0]   data_s;
  logic                               unused_addr_s;

  // Bits above the index are dropped, so the address space wraps.
  assign index_s       = addr[DEPTH_LOG2+WORD_INDEX_LSB-1:WORD_INDEX_LSB];
  assign unused_addr_s = ^addr;

  // Storage write port.
  always_ff @(posedge clk) begin
    if (enable && wr) begin
      mem_r[index_s] <= data_in;
    end
  end

  // Read sample enters stage 1 at the accepting edge; pre-edge contents are returned.
  assign valid_s[0] = enable & ~wr;
  assign data_s[0]  = mem_r[index_s];

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    mem_pipe_stage u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (valid_s[g]),
      .in_data   (data_s[g]),
      .out_valid (valid_s[g+1]),
      .out_data  (data_s[g+1])
    );
  end

  assign data_valid = valid_s[LATENCY];
  assign data_out   = data_s[LATENCY];
  assign busy       = |valid_s[LATENCY:1];

endmodule
